// File: rtl/approx_stats_pkg.sv
// Shared types and helpers for the approximate-multiplier error statistics block.
package approx_stats_pkg;

  localparam int OP_W   = 8;
  localparam int PROD_W = 16;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  // Returns {clamped, result}; lim is the all-ones value of the accumulator width.
  function automatic logic [64:0] sat_add(input logic [63:0]       acc,
                                          input logic [PROD_W-1:0] ed,
                                          input logic [63:0]       lim);
    logic [64:0] s;
    s = {1'b0, acc} + {49'd0, ed};
    if (s > {1'b0, lim}) sat_add = {1'b1, lim};
    else                 sat_add = s;
  endfunction

endpackage

// File: rtl/err_dist_stage.sv
// Two-stage datapath: exact product capture, then absolute error distance and error flag.
module err_dist_stage
  import approx_stats_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  input  logic [PROD_W-1:0] prod_approx,
  output logic              out_valid,
  output logic [PROD_W-1:0] ed,
  output logic              ne,
  output logic              busy
);

  logic [2:1]        vld_pipe_q, vld_pipe_d;
  logic [PROD_W-1:0] exact_q, exact_d;
  logic [PROD_W-1:0] approx_q, approx_d;
  logic [PROD_W-1:0] ed_q, ed_d;
  logic              ne_q, ne_d;
  logic [PROD_W-1:0] diff;

  always_comb begin
    vld_pipe_d = {vld_pipe_q[1], in_valid};
    exact_d    = exact_q;
    approx_d   = approx_q;
    ed_d       = ed_q;
    ne_d       = ne_q;
    diff       = (exact_q >= approx_q) ? (exact_q - approx_q) : (approx_q - exact_q);
    // Data registers only move with a valid so idle cycles don't toggle the datapath.
    if (in_valid) begin
      exact_d  = {8'd0, a} * {8'd0, b};
      approx_d = prod_approx;
    end
    if (vld_pipe_q[1]) begin
      ed_d = diff;
      ne_d = (diff != '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe_q <= '0;
      exact_q    <= '0;
      approx_q   <= '0;
      ed_q       <= '0;
      ne_q       <= 1'b0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      exact_q    <= exact_d;
      approx_q   <= approx_d;
      ed_q       <= ed_d;
      ne_q       <= ne_d;
    end
  end

  assign out_valid = vld_pipe_q[2];
  assign ed        = ed_q;
  assign ne        = ne_q;
  assign busy      = |vld_pipe_q;

endmodule

// File: rtl/approx_err_stats.sv
// Run-based error statistics (count, saturating ED sum, max ED) for approximate 8x8 products.
module approx_err_stats
  import approx_stats_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int ACC_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_samples,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  input  logic [PROD_W-1:0] prod_approx,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  err_count,
  output logic [ACC_W-1:0]  sum_ed,
  output logic [PROD_W-1:0] max_ed,
  output logic              sum_sat
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  n_q, n_d;
  logic [CNT_W-1:0]  acc_cnt_q, acc_cnt_d;
  logic [CNT_W-1:0]  err_count_q, err_count_d;
  logic [ACC_W-1:0]  sum_ed_q, sum_ed_d;
  logic [PROD_W-1:0] max_ed_q, max_ed_d;
  logic              sum_sat_q, sum_sat_d;
  logic              done_q, done_d;

  logic              fire;
  logic              s2_valid, s2_ne, pipe_busy;
  logic [PROD_W-1:0] s2_ed;
  logic [64:0]       add_res;
  logic [CNT_W-1:0]  acc_cnt_inc;

  assign in_ready = (state_q == RUN);
  assign fire     = in_valid & in_ready;

  err_dist_stage u_stage (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (fire),
    .a           (a),
    .b           (b),
    .prod_approx (prod_approx),
    .out_valid   (s2_valid),
    .ed          (s2_ed),
    .ne          (s2_ne),
    .busy        (pipe_busy)
  );

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    acc_cnt_d   = acc_cnt_q;
    err_count_d = err_count_q;
    sum_ed_d    = sum_ed_q;
    max_ed_d    = max_ed_q;
    sum_sat_d   = sum_sat_q;
    done_d      = 1'b0;
    acc_cnt_inc = acc_cnt_q + 1'b1;
    add_res     = sat_add(64'(sum_ed_q), s2_ed, 64'({ACC_W{1'b1}}));

    if (s2_valid) begin
      err_count_d = err_count_q + {{(CNT_W-1){1'b0}}, s2_ne};
      sum_ed_d    = add_res[ACC_W-1:0];
      sum_sat_d   = sum_sat_q | add_res[64];
      if (s2_ed > max_ed_q) max_ed_d = s2_ed;
    end

    case (state_q)
      IDLE, DONE: begin
        // Pipeline is empty here, so clearing stats cannot race an update.
        if (start) begin
          n_d         = num_samples;
          acc_cnt_d   = '0;
          err_count_d = '0;
          sum_ed_d    = '0;
          max_ed_d    = '0;
          sum_sat_d   = 1'b0;
          if (num_samples == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (fire) begin
          acc_cnt_d = acc_cnt_inc;
          if (acc_cnt_inc == n_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!pipe_busy) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      n_q         <= '0;
      acc_cnt_q   <= '0;
      err_count_q <= '0;
      sum_ed_q    <= '0;
      max_ed_q    <= '0;
      sum_sat_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      acc_cnt_q   <= acc_cnt_d;
      err_count_q <= err_count_d;
      sum_ed_q    <= sum_ed_d;
      max_ed_q    <= max_ed_d;
      sum_sat_q   <= sum_sat_d;
      done_q      <= done_d;
    end
  end

  assign busy      = (state_q == RUN) || (state_q == DRAIN);
  assign done      = done_q;
  assign err_count = err_count_q;
  assign sum_ed    = sum_ed_q;
  assign max_ed    = max_ed_q;
  assign sum_sat   = sum_sat_q;

endmodule

// File: tb/tb_approx_err_stats.sv
// Scoreboard bench for approx_err_stats with a 16-bit accumulator so saturation is reachable.
module tb_approx_err_stats;

  localparam int CNT_W = 16;
  localparam int ACC_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] num_samples;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       a, b;
  logic [15:0]      prod_approx;
  logic             busy, done;
  logic [CNT_W-1:0] err_count;
  logic [ACC_W-1:0] sum_ed;
  logic [15:0]      max_ed;
  logic             sum_sat;

  typedef struct {
    logic [15:0] ec;
    logic [15:0] sum;
    logic [15:0] mx;
    logic        sat;
  } res_t;

  res_t        exp_q[$];
  logic [7:0]  sa[$], sb[$];
  logic [15:0] sp[$];
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  approx_err_stats #(.CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .prod_approx(prod_approx), .busy(busy), .done(done),
    .err_count(err_count), .sum_ed(sum_ed), .max_ed(max_ed), .sum_sat(sum_sat)
  );

  task automatic load(input logic [7:0] ta, input logic [7:0] tb, input logic [15:0] tp);
    sa.push_back(ta); sb.push_back(tb); sp.push_back(tp);
  endtask

  task automatic do_start(input logic [CNT_W-1:0] n);
    @(negedge clk); start = 1'b1; num_samples = n;
    @(negedge clk); start = 1'b0;
  endtask

  // Waits for done, then pops the scoreboard and compares. hold keeps offering a sample.
  task automatic wait_done(input bit hold);
    int k;
    res_t e;
    k = 0;
    do begin
      @(negedge clk); k++;
      if (hold) begin
        in_valid = 1'b1; a = 8'd3; b = 8'd3; prod_approx = 16'd0;
        n_cmp++;
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL hold_ready got %b want 0", in_ready); end
      end else in_valid = 1'b0;
      if (done !== 1'b1) begin
        n_cmp++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL busy_drain got %b want 1", busy); end
      end
    end while (done !== 1'b1 && k < 20);
    in_valid = 1'b0;
    e = exp_q.pop_front();
    n_cmp++;
    if (done !== 1'b1 || k - 1 != 3) begin
      n_err++; $display("FAIL done_latency got %0d want 3 (done=%b)", k - 1, done);
    end
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL busy_done got %b want 0", busy); end
    n_cmp++;
    if (err_count !== e.ec) begin n_err++; $display("FAIL err_count got %0d want %0d", err_count, e.ec); end
    n_cmp++;
    if (sum_ed !== e.sum) begin n_err++; $display("FAIL sum_ed got %0d want %0d", sum_ed, e.sum); end
    n_cmp++;
    if (max_ed !== e.mx) begin n_err++; $display("FAIL max_ed got %0d want %0d", max_ed, e.mx); end
    n_cmp++;
    if (sum_sat !== e.sat) begin n_err++; $display("FAIL sum_sat got %b want %b", sum_sat, e.sat); end
  endtask

  // Models the loaded samples into the scoreboard, then drives them (optionally with gaps).
  task automatic drive_run(input bit gaps, input bit hold);
    res_t        e;
    int          idx, guard, ex, d;
    int unsigned s;
    bit          tog;
    e = '{16'd0, 16'd0, 16'd0, 1'b0};
    foreach (sa[i]) begin
      ex = int'(sa[i]) * int'(sb[i]);
      d  = (ex >= int'(sp[i])) ? ex - int'(sp[i]) : int'(sp[i]) - ex;
      if (d != 0) e.ec++;
      s = int'(e.sum) + d;
      if (s > 32'hFFFF) begin e.sum = 16'hFFFF; e.sat = 1'b1; end
      else e.sum = s[15:0];
      if (d > int'(e.mx)) e.mx = d[15:0];
    end
    exp_q.push_back(e);
    idx = 0; guard = 0; tog = 1'b0;
    while (idx < sa.size() && guard < 200) begin
      @(negedge clk); guard++;
      n_cmp++;
      if (busy !== 1'b1) begin n_err++; $display("FAIL busy_run got %b want 1", busy); end
      tog = ~tog;
      if (gaps && tog) in_valid = 1'b0;
      else begin in_valid = 1'b1; a = sa[idx]; b = sb[idx]; prod_approx = sp[idx]; end
      if (in_valid && in_ready) idx++;
    end
    n_cmp++;
    if (idx != sa.size()) begin n_err++; $display("FAIL transfers got %0d want %0d", idx, sa.size()); end
    sa.delete(); sb.delete(); sp.delete();
    wait_done(hold);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; num_samples = '0; in_valid = 1'b0;
    a = '0; b = '0; prod_approx = '0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({in_ready, busy, done, sum_sat} !== 4'b0 || err_count !== '0 || sum_ed !== '0 || max_ed !== '0) begin
      n_err++; $display("FAIL reset_outputs got rdy=%b busy=%b done=%b ec=%0d sum=%0d mx=%0d sat=%b want all 0",
                        in_ready, busy, done, err_count, sum_ed, max_ed, sum_sat);
    end
    rst = 1'b0;
  endtask

  task automatic test_exact();
    do_start(4);
    load(15, 15, 225); load(255, 255, 65025); load(0, 7, 0); load(16, 16, 256);
    drive_run(1'b0, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0) begin n_err++; $display("FAIL done_pulse got %b want 0", done); end
  endtask

  task automatic test_mixed();
    do_start(3);
    load(15, 15, 224); load(255, 255, 65000); load(10, 10, 110);
    drive_run(1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    do_start(2);
    load(7, 9, 60); load(200, 3, 600);
    drive_run(1'b1, 1'b1);
  endtask

  task automatic test_saturation();
    do_start(3);
    load(255, 255, 0); load(255, 255, 0); load(255, 255, 0);
    drive_run(1'b0, 1'b0);
  endtask

  task automatic test_zero();
    res_t e;
    exp_q.push_back('{16'd0, 16'd0, 16'd0, 1'b0});
    do_start(0);
    e = exp_q.pop_front();
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL zero_done got done=%b busy=%b want 1/0", done, busy);
    end
    n_cmp++;
    if (err_count !== e.ec || sum_ed !== e.sum || max_ed !== e.mx || sum_sat !== e.sat) begin
      n_err++; $display("FAIL zero_stats got ec=%0d sum=%0d mx=%0d sat=%b want 0", err_count, sum_ed, max_ed, sum_sat);
    end
  endtask

  task automatic test_start_in_run();
    do_start(2);
    @(negedge clk); start = 1'b1; num_samples = 16'd0;
    @(negedge clk); start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || done !== 1'b0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL start_ignored got busy=%b done=%b rdy=%b want 1/0/1", busy, done, in_ready);
    end
    load(12, 12, 140); load(2, 2, 4);
    drive_run(1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_start(1);
    load(100, 100, 9000);
    drive_run(1'b0, 1'b0);
    start = 1'b1; num_samples = 16'd1;
    @(negedge clk); start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || err_count !== '0 || sum_ed !== '0 || max_ed !== '0) begin
      n_err++; $display("FAIL b2b_clear got busy=%b ec=%0d sum=%0d mx=%0d want 1/0/0/0", busy, err_count, sum_ed, max_ed);
    end
    load(3, 5, 16);
    drive_run(1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    int guard;
    do_start(5);
    guard = 0;
    @(negedge clk); in_valid = 1'b1; a = 8'd50; b = 8'd50; prod_approx = 16'd0;
    @(negedge clk); a = 8'd40; b = 8'd40; prod_approx = 16'd1;
    @(posedge clk); #2 rst = 1'b1; #1;
    n_cmp++;
    if ({in_ready, busy, done, sum_sat} !== 4'b0 || err_count !== '0 || sum_ed !== '0 || max_ed !== '0) begin
      n_err++; $display("FAIL async_reset got rdy=%b busy=%b done=%b ec=%0d sum=%0d mx=%0d", in_ready, busy, done, err_count, sum_ed, max_ed);
    end
    in_valid = 1'b0;
    @(negedge clk); rst = 1'b0;
    do_start(1);
    load(9, 9, 80);
    drive_run(1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_exact();
    test_mixed();
    test_backpressure();
    test_saturation();
    test_zero();
    test_start_in_run();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
